// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer for the 8-bit ALU.
// Accepts 16-bit instructions over valid/ready, keeps a 4 x 8-bit register
// file, drives the ALU ports and writes results back.
//
//   state | meaning
//   IDLE  | ready for a new instruction (unless halted)
//   SETUP | operands on alu_a/alu_b, opcode parked at IDLE_OP
//   EXEC  | real opcode presented to the ALU
//   WB    | ALU result captured into rd at the end of this cycle
//   LOAD  | immediate written into rd at the end of this cycle
//   HALT  | sequencer stopped until reset
module alu_sequencer #(
  parameter logic [3:0] IDLE_OP = 4'b1111,
  parameter logic [7:0] REG_RST = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flag,
  output logic [7:0]  result,
  output logic        result_valid,
  output logic [3:0]  status_flag,
  output logic        illegal,
  output logic        halted,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EXEC, S_WB, S_LOAD, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state, state_next;
  logic [3:0]  op_q;
  logic [1:0]  rd_q;
  logic [7:0]  imm_q;
  logic [7:0]  regs [4];

  logic [3:0]  in_op;
  logic        in_alu, in_ldi, in_halt, in_illegal;
  logic        accept;

  assign in_op      = instr[15:12];
  assign in_alu     = (in_op[3] == 1'b0) && (in_op != 4'b0111);
  assign in_ldi     = (in_op == OP_LDI);
  assign in_halt    = (in_op == OP_HALT);
  assign in_illegal = !(in_alu || in_ldi || in_halt);
  assign accept     = (state == S_IDLE) && instr_valid && !halted;

  assign dbg_data = regs[dbg_sel];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus handshake and ALU opcode outputs.
  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    alu_opcode  = IDLE_OP;
    case (state)
      S_IDLE: begin
        instr_ready = !halted;
        if (accept) begin
          if (in_alu)       state_next = S_SETUP;
          else if (in_ldi)  state_next = S_LOAD;
          else if (in_halt) state_next = S_HALT;
          else              state_next = S_IDLE;
        end
      end
      S_SETUP: state_next = S_EXEC;
      S_EXEC: begin
        alu_opcode = op_q;
        state_next = S_WB;
      end
      S_WB: begin
        alu_opcode = op_q;
        state_next = S_IDLE;
      end
      S_LOAD:  state_next = S_IDLE;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Latch the accepted instruction and present operands read from the
  // pre-writeback register file; LDI/HALT/illegal leave the ALU ports idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= IDLE_OP;
      rd_q  <= 2'd0;
      imm_q <= 8'h00;
      alu_a <= 8'h00;
      alu_b <= 8'h00;
    end else if (accept) begin
      op_q  <= in_op;
      rd_q  <= instr[11:10];
      imm_q <= instr[7:0];
      if (in_alu) begin
        alu_a <= regs[instr[9:8]];
        alu_b <= regs[instr[7:6]];
      end
    end
  end

  // Pulses, sticky halt, writeback into the register file and status update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= REG_RST;
      result       <= 8'h00;
      result_valid <= 1'b0;
      status_flag  <= 4'b0000;
      illegal      <= 1'b0;
      halted       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      illegal      <= accept && in_illegal;
      if (accept && in_halt) halted <= 1'b1;
      if (state == S_WB) begin
        regs[rd_q]   <= alu_out;
        result       <= alu_out;
        result_valid <= 1'b1;
        // Logic/shift ops leave stale ALU flags, so zero is derived locally.
        if (op_q == OP_ADD || op_q == OP_SUB) status_flag <= alu_flag;
        else status_flag <= (alu_out == 8'h00) ? 4'b0010 : 4'b0000;
      end
      if (state == S_LOAD) begin
        regs[rd_q]   <= imm_q;
        result       <= imm_q;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, randomized
// instructions against a register-level reference model, reset and halt cases.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b;
  logic [7:0]  alu_out = 8'h00;
  logic [3:0]  alu_flag = 4'h0;
  logic [7:0]  result;
  logic        result_valid;
  logic [3:0]  status_flag;
  logic        illegal, halted;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] m_reg [4];
  logic [7:0] m_result;
  logic [3:0] m_flag;

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  res;
    logic [3:0]  flag;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_flag(alu_flag), .result(result),
    .result_valid(result_valid), .status_flag(status_flag), .illegal(illegal),
    .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // ALU stand-in: evaluates only when the opcode changes; logic ops keep old flags.
  always @(alu_opcode) begin : alu_stub
    int s;
    case (alu_opcode)
      4'h0: begin
        s = int'(alu_a) + int'(alu_b);
        alu_out  = 8'(s);
        alu_flag = (s > 255) ? 4'b1000 : ((8'(s) == 8'h00) ? 4'b0010 : 4'b0000);
      end
      4'h1: begin
        s = int'(alu_a) - int'(alu_b);
        alu_out  = 8'(s);
        alu_flag = (s < 0) ? 4'b0100 : ((s == 0) ? 4'b0010 : 4'b0000);
      end
      4'h2: alu_out = alu_a & alu_b;
      4'h3: alu_out = alu_a | alu_b;
      4'h4: alu_out = alu_a ^ alu_b;
      4'h5: alu_out = {alu_a[6:0], 1'b0};
      4'h6: alu_out = {1'b0, alu_a[7:1]};
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: kind 0 = ALU op, 1 = LDI, 2 = illegal, 3 = HALT.
  function automatic void model_exec(input logic [15:0] ins, output int kind);
    logic [3:0] op;
    int a, b, r;
    op = ins[15:12];
    a = int'(m_reg[ins[9:8]]);
    b = int'(m_reg[ins[7:6]]);
    r = 0;
    kind = 2;
    if (op <= 4'd6) begin
      kind = 0;
      case (op)
        4'd0: r = a + b;
        4'd1: r = a - b;
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a ^ b;
        4'd5: r = a * 2;
        default: r = a / 2;
      endcase
      m_result = 8'(r);
      m_reg[ins[11:10]] = 8'(r);
      if (op == 4'd0)      m_flag = (r > 255) ? 4'b1000 : ((m_result == 8'h00) ? 4'b0010 : 4'b0000);
      else if (op == 4'd1) m_flag = (r < 0) ? 4'b0100 : ((r == 0) ? 4'b0010 : 4'b0000);
      else                 m_flag = (m_result == 8'h00) ? 4'b0010 : 4'b0000;
    end else if (op == 4'd8) begin
      kind = 1;
      m_result = ins[7:0];
      m_reg[ins[11:10]] = ins[7:0];
    end else if (op == 4'd15) begin
      kind = 3;
    end
  endfunction

  task automatic chk_regs(input string tag);
    for (int k = 0; k < 4; k++) begin
      dbg_sel = 2'(k);
      #1;
      chk($sformatf("%s dbg r%0d", tag, k), dbg_data, m_reg[k]);
    end
  endtask

  // Issue one instruction and check its full life cycle against the model.
  // With use_model=0 the result/flag expectations come from the caller.
  task automatic run_instr(input logic [15:0] ins, input logic use_model,
                           input logic [7:0] t_res, input logic [3:0] t_flag);
    int w, c, kind, lat;
    logic [7:0] a_exp, b_exp, e_res;
    logic [3:0] e_flag;
    w = 0;
    while (!instr_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("ready before issue", instr_ready, 1'b1);
    a_exp = m_reg[ins[9:8]];
    b_exp = m_reg[ins[7:6]];
    model_exec(ins, kind);
    e_res  = use_model ? m_result : t_res;
    e_flag = use_model ? m_flag : t_flag;
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    c = 1;
    if (kind == 2) begin
      chk("illegal pulse", illegal, 1'b1);
      chk("ready after illegal", instr_ready, 1'b1);
      chk("no wb on illegal", result_valid, 1'b0);
      @(posedge clk); #1;
      chk("illegal one cycle", illegal, 1'b0);
      chk("result kept", result, m_result);
      chk("flag kept", status_flag, m_flag);
    end else begin
      lat = (kind == 0) ? 4 : 2;
      if (kind == 0) begin
        chk("setup opcode", alu_opcode, 4'hF);
        chk("setup alu_a", alu_a, a_exp);
        chk("setup alu_b", alu_b, b_exp);
      end
      while (!result_valid && c < 8) begin
        @(posedge clk); #1; c++;
        if (c == 2 && kind == 0) chk("exec opcode", alu_opcode, ins[15:12]);
      end
      chk("latency", c, lat);
      chk("result", result, e_res);
      chk("status_flag", status_flag, e_flag);
      chk("idle opcode", alu_opcode, 4'hF);
    end
    chk_regs("post");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses, ill_cnt, sel, op, r;
    tbl[0]  = '{16'h84C8, 8'hC8, 4'b0000};
    tbl[1]  = '{16'h8864, 8'h64, 4'b0000};
    tbl[2]  = '{16'h0D80, 8'h2C, 4'b1000};
    tbl[3]  = '{16'h8464, 8'h64, 4'b1000};
    tbl[4]  = '{16'h1240, 8'h00, 4'b0010};
    tbl[5]  = '{16'h8810, 8'h10, 4'b0010};
    tbl[6]  = '{16'h1240, 8'hAC, 4'b0100};
    tbl[7]  = '{16'h84F0, 8'hF0, 4'b0100};
    tbl[8]  = '{16'h880F, 8'h0F, 4'b0100};
    tbl[9]  = '{16'h2180, 8'h00, 4'b0010};
    tbl[10] = '{16'h84FF, 8'hFF, 4'b0010};
    tbl[11] = '{16'h2180, 8'h0F, 4'b0000};
    tbl[12] = '{16'h8441, 8'h41, 4'b0000};
    tbl[13] = '{16'h5500, 8'h82, 4'b0000};
    tbl[14] = '{16'h5500, 8'h04, 4'b0000};

    for (int k = 0; k < 4; k++) m_reg[k] = 8'h00;
    m_result = 8'h00;
    m_flag   = 4'b0000;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    dbg_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst alu_opcode", alu_opcode, 4'hF);
    chk("rst alu_a", alu_a, 8'h00);
    chk("rst alu_b", alu_b, 8'h00);
    chk("rst result", result, 8'h00);
    chk("rst status", status_flag, 4'b0000);
    chk("rst result_valid", result_valid, 1'b0);
    chk("rst illegal", illegal, 1'b0);
    chk("rst halted", halted, 1'b0);
    chk_regs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_instr(tbl[i].ins, 1'b0, tbl[i].res, tbl[i].flag);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 6) op = r;
      else if (r <= 8) op = 8;
      else begin
        sel = int'($urandom_range(0, 6));
        op = (sel == 0) ? 7 : 8 + sel;
      end
      run_instr({4'(op), 12'($urandom)}, 1'b1, 8'h00, 4'h0);
    end

    // Reset in the middle of an ADD.
    run_instr(16'h8430, 1'b1, 8'h00, 4'h0);
    run_instr(16'h8822, 1'b1, 8'h00, 4'h0);
    instr_valid = 1'b1;
    instr = 16'h0D80;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("exec before reset", alu_opcode, 4'h0);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) m_reg[k] = 8'h00;
    m_result = 8'h00;
    m_flag   = 4'b0000;
    chk("abort opcode", alu_opcode, 4'hF);
    chk("abort result", result, 8'h00);
    chk("abort status", status_flag, 4'b0000);
    chk("abort result_valid", result_valid, 1'b0);
    chk_regs("abort");
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    chk("no wb after abort", pulses, 0);
    chk("ready after abort", instr_ready, 1'b1);

    // Illegal then HALT with valid held high, then ignored traffic.
    run_instr(16'h845A, 1'b1, 8'h00, 4'h0);
    instr_valid = 1'b1;
    instr = 16'h7123;
    @(posedge clk); #1;
    chk("held illegal pulse", illegal, 1'b1);
    chk("held ready", instr_ready, 1'b1);
    instr = 16'hF000;
    @(posedge clk); #1;
    chk("halt illegal low", illegal, 1'b0);
    chk("halted set", halted, 1'b1);
    chk("halted ready", instr_ready, 1'b0);
    instr = 16'h8477;
    pulses = 0;
    ill_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
      if (illegal) ill_cnt++;
    end
    instr_valid = 1'b0;
    chk("halt ignores wb", pulses, 0);
    chk("halt ignores illegal", ill_cnt, 0);
    chk("halted sticky", halted, 1'b1);
    chk("halted ready sticky", instr_ready, 1'b0);
    chk("halt result", result, 8'h5A);
    chk_regs("halt");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
